// File: rtl/shifter_right_seq_if.sv
// Handshake and data bundle for the sequential right shifter.
// master issues requests, slave is the shifter.
interface shifter_right_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [31:0]      dataB;
  logic [5:0]       Signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;

  modport master (
    output start, dataA, dataB, Signal,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, dataA, dataB, Signal,
    output busy, done, dataOut
  );
endinterface

// File: rtl/shifter_right_seq.sv
// Multi-cycle SRL/SRA shifter, one bit per clock.
// Start/busy/done handshake; result held until next completion.
module shifter_right_seq #(
  parameter int         WIDTH   = 32,
  parameter int         SHAMT_W = 5,
  parameter logic [5:0] SRL     = 6'b000010,
  parameter logic [5:0] SRA     = 6'b000011
) (
  input logic clk,
  input logic reset_n,
  shifter_right_seq_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [WIDTH-1:0]   shReg;
  logic [SHAMT_W-1:0] cnt;
  logic               fill;
  logic               doneQ;
  logic [WIDTH-1:0]   outQ;

  logic               load;
  logic               finish;
  logic [SHAMT_W-1:0] cntLoad;
  logic               fillLoad;
  logic               isSrl;
  logic               isSra;

  assign isSrl = (bus.Signal == SRL);
  assign isSra = (bus.Signal == SRA);

  // Capture values: unknown opcodes load a zero count (pass-through).
  always_comb begin
    cntLoad  = '0;
    fillLoad = 1'b0;
    unique case (1'b1)
      isSrl: begin
        cntLoad = bus.dataB[SHAMT_W-1:0];
      end
      isSra: begin
        cntLoad  = bus.dataB[SHAMT_W-1:0];
        fillLoad = bus.dataA[WIDTH-1];
      end
      default: begin
        cntLoad = '0;
      end
    endcase
  end

  // Next-state and control strobes.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Shift datapath, completion pulse and held result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shReg <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
      doneQ <= 1'b0;
      outQ  <= '0;
    end else begin
      doneQ <= finish;
      if (load) begin
        shReg <= bus.dataA;
        cnt   <= cntLoad;
        fill  <= fillLoad;
      end else if (state == SHIFT && cnt != '0) begin
        shReg <= {fill, shReg[WIDTH-1:1]};
        cnt   <= cnt - SHAMT_W'(1);
      end
      if (finish) begin
        outQ <= shReg;
      end
    end
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.done    = doneQ;
  assign bus.dataOut = outQ;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Scoreboard bench for the sequential right shifter.
// Stimulus pushes expected result and done cycle; monitor pops on done.
module tb_shifter_right_seq;

  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  typedef struct {
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q[$];

  shifter_right_seq_if #(.WIDTH(32)) bus ();

  shifter_right_seq dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=%h at cyc=%0d", bus.dataOut, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.dataOut !== e.data || cyc != e.at) begin
          failures++;
          $display("FAIL %s got=%h@%0d expected=%h@%0d",
                   e.name, bus.dataOut, cyc, e.data, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Called at a negedge: drives one start pulse, then scrambles operands.
  task automatic issue(input string name, input logic [5:0] sig,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input int amt);
    exp_t e;
    bus.Signal = sig;
    bus.dataA  = a;
    bus.dataB  = b;
    bus.start  = 1'b1;
    e.data = want;
    e.at   = cyc + amt + 2;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.dataA  = ~a;
    bus.dataB  = b ^ 32'h15;
    bus.Signal = ~sig;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d expected=0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int n;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.Signal = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_out", bus.dataOut, 32'd0);

    issue("srl_4", SRL, 32'hF000_0000, 32'd4, 32'h0F00_0000, 4);
    drain("srl_4");

    issue("sra_31", SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("sra_31_busy_cycles", n, 32'd32);
    drain("sra_31");

    issue("srl_31", SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 31);
    drain("srl_31");

    issue("srl_amt0", SRL, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 0);
    drain("srl_amt0");

    issue("bad_op", 6'b000000, 32'hDEAD_BEEF, 32'd7, 32'hDEAD_BEEF, 0);
    drain("bad_op");

    issue("sra_pos", SRA, 32'h7000_0000, 32'd4, 32'h0700_0000, 4);
    drain("sra_pos");
    issue("sra_8", SRA, 32'h8765_4321, 32'h0000_0108, 32'hFF87_6543, 8);
    drain("sra_8");
    issue("srl_8", SRL, 32'h8765_4321, 32'd8, 32'h0087_6543, 8);
    drain("srl_8");

    repeat (5) @(negedge clk);
    check("hold_out", bus.dataOut, 32'h0087_6543);

    issue("mid_start", SRL, 32'hFFFF_0000, 32'd16, 32'h0000_FFFF, 16);
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    bus.Signal = SRA;
    bus.dataA  = 32'h8000_0000;
    bus.dataB  = 32'd1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain("mid_start");
    repeat (20) @(negedge clk);

    issue("b2b_first", SRA, 32'h8000_0000, 32'd2, 32'hE000_0000, 2);
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", {31'd0, bus.done}, 32'd1);
    issue("b2b_second", SRL, 32'h0000_00F0, 32'd4, 32'h0000_000F, 4);
    drain("b2b");

    issue("rst_abort", SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_out", bus.dataOut, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_out", bus.dataOut, 32'd0);

    issue("post_rst", SRA, 32'hF000_000F, 32'd3, 32'hFE00_0001, 3);
    drain("post_rst");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
